// File: rtl/nat_split_n_sync_pkg.sv
// Shared types and helpers for the N-way natural split and its delay counter.
package nat_split_n_sync_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Width of a counter that must hold values 0..dly; never narrower than 1 bit.
    function automatic int cnt_w(input int dly);
        return (dly < 1) ? 1 : $clog2(dly + 1);
    endfunction

endpackage

// File: rtl/nat_split_n_sync_free_delay_cnt.sv
// Load/decrement counter: after i_load, o_done pulses for one cycle FREE_DLY cycles later.
// A load while counting restarts the delay.
module free_delay_cnt
    import nat_split_n_sync_pkg::*;
#(
    parameter int FREE_DLY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam int CW = cnt_w(FREE_DLY);
    localparam logic [CW-1:0] LOAD_VAL = CW'(FREE_DLY);

    logic [CW-1:0] r_cnt;
    logic          r_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_act <= 1'b0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
            r_act <= 1'b1;
        end else if (r_act) begin
            if (r_cnt == '0) begin
                r_act <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign o_done = r_act && (r_cnt == '0);

endmodule

// File: rtl/nat_split_n_sync.sv
// Forks one drive token plus payload to a masked subset of N_OUT branches and
// returns a single upstream free FREE_DLY cycles after the last selected branch frees.
module nat_split_n_sync
    import nat_split_n_sync_pkg::*;
#(
    parameter int N_OUT    = 4,
    parameter int DW       = 32,
    parameter int FREE_DLY = 2,
    parameter int MASK_EN  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_drive,
    input  logic [DW-1:0]    i_data,
    input  logic [N_OUT-1:0] i_mask,
    output logic             o_free,
    output logic [N_OUT-1:0] o_driveNext,
    output logic [DW-1:0]    o_dataNext,
    input  logic [N_OUT-1:0] i_freeNext,
    output logic             o_busy,
    output logic             o_err
);

    state_t             r_state, w_state_nxt;
    logic [N_OUT-1:0]   r_pending, w_pending_nxt;
    logic [N_OUT-1:0]   r_drive;
    logic [N_OUT-1:0]   w_eff_mask;
    logic [DW-1:0]      r_data;
    logic               r_err, w_err_set;
    logic               w_accept, w_load, w_done;

    assign w_eff_mask = (MASK_EN != 0) ? i_mask : '1;
    // The o_free cycle is already idle from the producer's view, so a new token is taken.
    assign w_accept   = i_drive && ((r_state == S_IDLE) || w_done);

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_load        = 1'b0;
        w_err_set     = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_WAIT: begin
                w_err_set     = |(i_freeNext & ~r_pending);
                w_pending_nxt = r_pending & ~i_freeNext;
                if (w_pending_nxt == '0) begin
                    w_state_nxt = S_RELEASE;
                    w_load      = 1'b1;
                end
            end
            S_RELEASE: begin
                w_err_set = |i_freeNext;
                if (w_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_drive && !w_accept) w_err_set = 1'b1;
        if (w_accept) begin
            w_pending_nxt = w_eff_mask;
            if (w_eff_mask == '0) begin
                w_state_nxt = S_RELEASE;
                w_load      = 1'b1;
            end else begin
                w_state_nxt = S_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_drive   <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_drive   <= w_accept ? w_eff_mask : '0;
            if (w_accept) r_data <= i_data;
            r_err     <= r_err | w_err_set;
        end
    end

    free_delay_cnt #(
        .FREE_DLY (FREE_DLY)
    ) u_free_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .o_done (w_done)
    );

    assign o_free      = w_done;
    assign o_driveNext = r_drive;
    assign o_dataNext  = r_data;
    assign o_busy      = (r_state != S_IDLE);
    assign o_err       = r_err;

endmodule

// File: tb/tb_nat_split_n_sync.sv
// Directed bench: a broadcast/empty/subset vector table plus hand sequences for
// MASK_EN=0, reset mid-token, back-to-back tokens and busy drops.
module tb_nat_split_n_sync;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_drive;
    logic [31:0] i_data;
    logic [3:0]  i_mask;
    logic        o_free;
    logic [3:0]  o_driveNext;
    logic [31:0] o_dataNext;
    logic [3:0]  i_freeNext;
    logic        o_busy;
    logic        o_err;

    logic        d2_drive;
    logic [31:0] d2_data;
    logic [3:0]  d2_mask;
    logic        d2_free;
    logic [3:0]  d2_driveNext;
    logic [31:0] d2_dataNext;
    logic [3:0]  d2_freeNext;
    logic        d2_busy;
    logic        d2_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nat_split_n_sync #(.N_OUT(4), .DW(32), .FREE_DLY(2), .MASK_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_drive(i_drive), .i_data(i_data), .i_mask(i_mask),
        .o_free(o_free), .o_driveNext(o_driveNext), .o_dataNext(o_dataNext),
        .i_freeNext(i_freeNext), .o_busy(o_busy), .o_err(o_err)
    );

    nat_split_n_sync #(.N_OUT(4), .DW(32), .FREE_DLY(0), .MASK_EN(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_drive(d2_drive), .i_data(d2_data), .i_mask(d2_mask),
        .o_free(d2_free), .o_driveNext(d2_driveNext), .o_dataNext(d2_dataNext),
        .i_freeNext(d2_freeNext), .o_busy(d2_busy), .o_err(d2_err)
    );

    typedef struct {
        logic        drv;
        logic [31:0] dat;
        logic [3:0]  msk;
        logic [3:0]  fre;
        logic [3:0]  e_drv;
        logic [31:0] e_dat;
        logic        e_free;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(input logic drv, input logic [31:0] dat, input logic [3:0] msk,
                                input logic [3:0] fre, input logic [3:0] e_drv,
                                input logic [31:0] e_dat, input logic e_free,
                                input logic e_busy, input logic e_err);
        vec_t v;
        v.drv = drv; v.dat = dat; v.msk = msk; v.fre = fre;
        v.e_drv = e_drv; v.e_dat = e_dat; v.e_free = e_free; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply inputs just after the edge that opens a cycle, then return mid-cycle for sampling.
    task automatic step(input logic d, input logic [31:0] dt, input logic [3:0] m,
                        input logic [3:0] f);
        @(posedge clk);
        #1;
        i_drive = d; i_data = dt; i_mask = m; i_freeNext = f;
        @(negedge clk);
    endtask

    task automatic step2(input logic d, input logic [31:0] dt, input logic [3:0] m,
                         input logic [3:0] f);
        @(posedge clk);
        #1;
        d2_drive = d; d2_data = dt; d2_mask = m; d2_freeNext = f;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        i_drive = 1'b0; i_data = '0; i_mask = '0; i_freeNext = '0;
        d2_drive = 1'b0; d2_data = '0; d2_mask = '0; d2_freeNext = '0;

        vt[0]  = mk(1, 32'hDEADBEEF, 4'hF, 4'h0, 4'h0, 32'h0,        0, 0, 0);
        vt[1]  = mk(0, 32'h0,        4'h0, 4'h0, 4'hF, 32'hDEADBEEF, 0, 1, 0);
        vt[2]  = mk(0, 32'h0,        4'h0, 4'h1, 4'h0, 32'hDEADBEEF, 0, 1, 0);
        vt[3]  = mk(0, 32'h0,        4'h0, 4'h6, 4'h0, 32'hDEADBEEF, 0, 1, 0);
        vt[4]  = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'hDEADBEEF, 0, 1, 0);
        vt[5]  = mk(0, 32'h0,        4'h0, 4'h8, 4'h0, 32'hDEADBEEF, 0, 1, 0);
        vt[6]  = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'hDEADBEEF, 0, 1, 0);
        vt[7]  = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'hDEADBEEF, 0, 1, 0);
        vt[8]  = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'hDEADBEEF, 1, 1, 0);
        vt[9]  = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'hDEADBEEF, 0, 0, 0);
        vt[10] = mk(1, 32'hA5A5A5A5, 4'h0, 4'h0, 4'h0, 32'hDEADBEEF, 0, 0, 0);
        vt[11] = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'hA5A5A5A5, 0, 1, 0);
        vt[12] = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'hA5A5A5A5, 0, 1, 0);
        vt[13] = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'hA5A5A5A5, 1, 1, 0);
        vt[14] = mk(1, 32'h12345678, 4'h5, 4'h0, 4'h0, 32'hA5A5A5A5, 0, 0, 0);
        vt[15] = mk(0, 32'h0,        4'h0, 4'h0, 4'h5, 32'h12345678, 0, 1, 0);
        vt[16] = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'h12345678, 0, 1, 0);
        vt[17] = mk(0, 32'h0,        4'h0, 4'h5, 4'h0, 32'h12345678, 0, 1, 0);
        vt[18] = mk(0, 32'h0,        4'h0, 4'h2, 4'h0, 32'h12345678, 0, 1, 0);
        vt[19] = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'h12345678, 0, 1, 1);
        vt[20] = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'h12345678, 1, 1, 1);
        vt[21] = mk(0, 32'h0,        4'h0, 4'h0, 4'h0, 32'h12345678, 0, 0, 1);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst drv",  32'(o_driveNext), 32'h0);
        chk("rst data", o_dataNext,       32'h0);
        chk("rst free", 32'(o_free),      32'h0);
        chk("rst busy", 32'(o_busy),      32'h0);
        chk("rst err",  32'(o_err),       32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // MASK_EN=0, FREE_DLY=0: mask ignored, free one cycle after the last branch free
        step2(1, 32'h00C0FFEE, 4'h1, 4'h0);
        step2(0, 32'h0, 4'h0, 4'h0);
        chk("m0 drv",  32'(d2_driveNext), 32'hF);
        chk("m0 data", d2_dataNext,       32'h00C0FFEE);
        step2(0, 32'h0, 4'h0, 4'hF);
        chk("m0 free early", 32'(d2_free), 32'h0);
        step2(0, 32'h0, 4'h0, 4'h0);
        chk("m0 free", 32'(d2_free), 32'h1);
        step2(0, 32'h0, 4'h0, 4'h0);
        chk("m0 idle busy", 32'(d2_busy), 32'h0);
        chk("m0 err",       32'(d2_err),  32'h0);

        // Broadcast, empty mask, subset fork with stray free
        for (int i = 0; i < 22; i++) begin
            step(vt[i].drv, vt[i].dat, vt[i].msk, vt[i].fre);
            chk($sformatf("v%0d drv", i),  32'(o_driveNext), 32'(vt[i].e_drv));
            chk($sformatf("v%0d data", i), o_dataNext,       vt[i].e_dat);
            chk($sformatf("v%0d free", i), 32'(o_free),      32'(vt[i].e_free));
            chk($sformatf("v%0d busy", i), 32'(o_busy),      32'(vt[i].e_busy));
            chk($sformatf("v%0d err", i),  32'(o_err),       32'(vt[i].e_err));
        end

        // Reset in the middle of WAIT abandons the token
        step(1, 32'h11111111, 4'hF, 4'h0);
        step(0, 32'h0, 4'h0, 4'h0);
        chk("rw drv", 32'(o_driveNext), 32'hF);
        step(0, 32'h0, 4'h0, 4'h1);
        @(posedge clk);
        #1;
        i_freeNext = '0;
        rst_n = 1'b0;
        #1;
        chk("rw rst drv",  32'(o_driveNext), 32'h0);
        chk("rw rst data", o_dataNext,       32'h0);
        chk("rw rst free", 32'(o_free),      32'h0);
        chk("rw rst busy", 32'(o_busy),      32'h0);
        chk("rw rst err",  32'(o_err),       32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(0, 32'h0, 4'h0, 4'h0);
            chk($sformatf("rw quiet free %0d", i), 32'(o_free), 32'h0);
            chk($sformatf("rw quiet busy %0d", i), 32'(o_busy), 32'h0);
        end
        step(1, 32'hDEADBEEF, 4'hF, 4'h0);
        step(0, 32'h0, 4'h0, 4'h0);
        chk("rb drv",  32'(o_driveNext), 32'hF);
        chk("rb data", o_dataNext,       32'hDEADBEEF);
        step(0, 32'h0, 4'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 4'h0, 4'h0);
            chk($sformatf("rb free %0d", i), 32'(o_free), (i == 2) ? 32'h1 : 32'h0);
        end
        step(0, 32'h0, 4'h0, 4'h0);
        chk("rb busy", 32'(o_busy), 32'h0);
        chk("rb err",  32'(o_err),  32'h0);

        // Busy drop during WAIT, then back-to-back drive in the o_free cycle
        step(1, 32'hCAFEF00D, 4'h3, 4'h0);
        step(1, 32'h0BADBEEF, 4'hF, 4'h0);
        chk("bb drv1",     32'(o_driveNext), 32'h3);
        chk("bb err pre",  32'(o_err),       32'h0);
        step(0, 32'h0, 4'h0, 4'h3);
        chk("bb err drop", 32'(o_err),       32'h1);
        chk("bb data kept", o_dataNext,      32'hCAFEF00D);
        chk("bb no redrv", 32'(o_driveNext), 32'h0);
        step(0, 32'h0, 4'h0, 4'h0);
        chk("bb free c4", 32'(o_free), 32'h0);
        step(0, 32'h0, 4'h0, 4'h0);
        chk("bb free c5", 32'(o_free), 32'h0);
        step(1, 32'h55AA55AA, 4'hC, 4'h0);
        chk("bb free c6", 32'(o_free), 32'h1);
        step(0, 32'h0, 4'h0, 4'h0);
        chk("bb drv2",  32'(o_driveNext), 32'hC);
        chk("bb data2", o_dataNext,       32'h55AA55AA);
        chk("bb busy2", 32'(o_busy),      32'h1);
        step(0, 32'h0, 4'h0, 4'hC);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 4'h0, 4'h0);
            chk($sformatf("bb free2 %0d", i), 32'(o_free), (i == 2) ? 32'h1 : 32'h0);
        end
        step(0, 32'h0, 4'h0, 4'h0);
        chk("bb end busy", 32'(o_busy), 32'h0);
        chk("bb end err",  32'(o_err),  32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/nat_split_n_sync.md
Name: nat_split_n_sync

Overview:
- Parametrised, clocked successor of the two-way natural split.
- Forks one drive/free token, plus a data payload, to N_OUT downstream stages.
- Accepts a per-token branch mask, so it can broadcast or fork to a subset of branches.
- Returns a single upstream free once every selected branch has freed, after a programmable release delay.
- Sits between a producer stage and N_OUT parallel consumer stages in the fpgaCtrl control fabric.

Parameters:
- N_OUT, 4: number of output branches (2..16).
- DW, 32: payload width.
- FREE_DLY, 2: extra cycles between the last branch free and o_free (0..15).
- MASK_EN, 1: 1 = i_mask selects the branches; 0 = i_mask is ignored and the block always broadcasts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_drive  in  1  single-cycle drive pulse from upstream
- i_data  in  DW  payload, sampled with i_drive
- i_mask  in  N_OUT  branch select, sampled with i_drive
- o_free  out  1  single-cycle free pulse to upstream
- o_driveNext  out  N_OUT  per-branch single-cycle drive pulses
- o_dataNext  out  DW  registered payload, common to all branches
- i_freeNext  in  N_OUT  per-branch single-cycle free pulses
- o_busy  out  1  high whenever state is not IDLE
- o_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, pending=0, counter=0. Outputs o_free=0, o_driveNext=0, o_dataNext=0, o_busy=0, o_err=0. Reset mid-operation abandons the token; no free is emitted.
- States: IDLE, WAIT, RELEASE.
- IDLE, i_drive=1:
  - Latch i_data into o_dataNext.
  - Set pending = MASK_EN ? i_mask : all-ones.
  - Next cycle: o_driveNext = pending for exactly one cycle (latency 1). Go to WAIT.
  - If the effective mask is 0: drive no branch and go directly to RELEASE.
- WAIT:
  - i_freeNext[k]=1 with pending[k]=1 clears pending[k].
  - i_freeNext[k]=1 with pending[k]=0 is ignored and sets o_err.
  - Frees are accepted from the cycle o_driveNext is high onward.
  - Several frees in one cycle are all accepted.
  - When pending becomes 0, load the counter with FREE_DLY and go to RELEASE.
- RELEASE:
  - Decrement the counter each cycle.
  - In the cycle the counter is 0: o_free=1 for one cycle, then go to IDLE.
  - Timing: last free sampled in cycle t gives o_free in cycle t+1+FREE_DLY.
  - Any i_freeNext arriving in RELEASE sets o_err.
- Back-to-back tokens: i_drive in the same cycle as o_free is accepted as a new token.
- i_drive while busy (any other WAIT/RELEASE cycle): dropped and sets o_err. The current token is unaffected.
- o_dataNext holds its value from capture until the next accepted drive.
- o_err clears only on reset.
- Width rules:
  - Counter width is $clog2(FREE_DLY+1), minimum 1.
  - pending is N_OUT bits.
  - No arithmetic on the payload.

Decomposition:
- Shared package/include holds:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, RELEASE=2'd2);
  - a clog2-based counter-width macro.
- One natural sub-module: free_delay_cnt. It is a load/decrement counter that outputs a done pulse, parametrised by FREE_DLY, and is reused wherever fixed cycle delays replace the old delay-cell chains.

Test Plan:
- Broadcast (MASK_EN=1, N_OUT=4, FREE_DLY=2): i_drive cycle 1 with i_data=0xDEADBEEF, i_mask=4'b1111 -> o_driveNext=4'b1111 in cycle 2 and o_dataNext=0xDEADBEEF. i_freeNext bits in cycles 3, 4, 4, 6 -> o_free in cycle 9 only. o_err=0.
- Subset fork: i_mask=4'b0101 -> o_driveNext=4'b0101. Frees on bits 0 and 2 in cycle 4 -> o_free in cycle 7. A later stray free on bit 1 -> o_err=1.
- Empty mask: i_mask=0 in cycle 1 -> no o_driveNext, o_free in cycle 4 (FREE_DLY=2).
- Back-to-back plus busy drop: a second i_drive in the o_free cycle -> new o_driveNext the next cycle. An i_drive during WAIT -> ignored, o_err=1, first token still completes.
- MASK_EN=0, FREE_DLY=0: i_mask=0001 is ignored -> o_driveNext=all ones. All frees in cycle 3 -> o_free in cycle 4.
- Reset mid-WAIT: rst_n low in cycle 4 -> all outputs 0 immediately. No o_free after release. A new drive then behaves as in the broadcast case.
